// File: rtl/fetch_unit.sv
// fetch_unit: MIPS instruction-fetch stage with IF/ID register.
// Keeps one word request outstanding to instruction memory, captures the
// returned instruction with its PC, and loads the next PC from downstream
// when decode consumes the instruction. A redirect always wins; a redirect
// while a response is in flight sends the FSM to DRAIN so that response is
// dropped.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned fetch PC stops
// fetching in ERR and raises a sticky fetch_misalign until a redirect).
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] npc,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] fetch_pc,
    output logic        fetch_misalign
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_DECODE,
        ST_DRAIN,
        ST_ERR
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_fetch_pc;
    logic [31:0] w_fetch_pc_next;
    logic        r_if_id_valid;
    logic        w_if_id_valid_next;
    logic [31:0] r_if_id_instr;
    logic [31:0] w_if_id_instr_next;
    logic [31:0] r_if_id_pc;
    logic [31:0] w_if_id_pc_next;
    logic        w_gnt;

`ifdef FETCH_ALIGN_CHECK_EN
    logic        r_misalign;
    logic        w_misalign_next;
    logic        w_pc_misaligned;

    // Request only from registered state; a misaligned PC never goes out.
    assign w_pc_misaligned = (r_fetch_pc[1:0] != 2'b00);
    assign imem_req        = (r_state == ST_FETCH) && !w_pc_misaligned;
    assign imem_addr       = r_fetch_pc;
    assign fetch_misalign  = r_misalign;
`else
    // Low address bits are forced to zero so memory always sees a word address.
    assign imem_req        = (r_state == ST_FETCH);
    assign imem_addr       = {r_fetch_pc[31:2], 2'b00};
    assign fetch_misalign  = 1'b0;
`endif

    // A grant only counts while a request is actually being presented.
    assign w_gnt = imem_req & imem_gnt;

    assign if_id_valid = r_if_id_valid;
    assign if_id_instr = r_if_id_instr;
    assign if_id_pc    = r_if_id_pc;
    assign fetch_pc    = r_fetch_pc;

    // Next-state and next-register logic; redirect overrides everything last.
    always_comb begin
        w_state_next       = r_state;
        w_fetch_pc_next    = r_fetch_pc;
        w_if_id_valid_next = r_if_id_valid;
        w_if_id_instr_next = r_if_id_instr;
        w_if_id_pc_next    = r_if_id_pc;
`ifdef FETCH_ALIGN_CHECK_EN
        w_misalign_next    = r_misalign;
`endif
        case (r_state)
            ST_IDLE: w_state_next = ST_FETCH;
            ST_FETCH: begin
`ifdef FETCH_ALIGN_CHECK_EN
                if (w_pc_misaligned) begin
                    w_misalign_next = 1'b1;
                    w_state_next    = ST_ERR;
                end else
`endif
                if (w_gnt) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    w_if_id_instr_next = imem_rdata;
                    w_if_id_pc_next    = r_fetch_pc;
                    w_if_id_valid_next = 1'b1;
                    w_state_next       = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (!stall) begin
                    w_fetch_pc_next    = npc;
                    w_if_id_valid_next = 1'b0;
                    w_state_next       = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (imem_rvalid) begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_ERR: w_state_next = ST_ERR;
            default: w_state_next = ST_IDLE;
        endcase

        if (redirect) begin
            w_fetch_pc_next    = redirect_pc;
            w_if_id_valid_next = 1'b0;
            w_if_id_instr_next = r_if_id_instr;
            w_if_id_pc_next    = r_if_id_pc;
`ifdef FETCH_ALIGN_CHECK_EN
            w_misalign_next    = 1'b0;
`endif
            // Any response already granted must be swallowed before refetching.
            if ((r_state == ST_WAIT) || (r_state == ST_DRAIN) ||
                ((r_state == ST_FETCH) && w_gnt)) begin
                w_state_next = ST_DRAIN;
            end else begin
                w_state_next = ST_FETCH;
            end
        end
    end

    // State and IF/ID registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_fetch_pc    <= RESET_PC;
            r_if_id_valid <= 1'b0;
            r_if_id_instr <= 32'h0;
            r_if_id_pc    <= 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
            r_misalign    <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_next;
            r_fetch_pc    <= w_fetch_pc_next;
            r_if_id_valid <= w_if_id_valid_next;
            r_if_id_instr <= w_if_id_instr_next;
            r_if_id_pc    <= w_if_id_pc_next;
`ifdef FETCH_ALIGN_CHECK_EN
            r_misalign    <= w_misalign_next;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios followed by randomized traffic, checked
// every cycle against a transaction-level model of the fetch stage.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] npc;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] fetch_pc;
    logic        fetch_misalign;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: what the fetch stage owes the outside world.
    logic        m_started;   // first cycle after reset has elapsed
    logic [31:0] m_fetch;     // PC of the next/ongoing fetch
    logic        m_valid;     // instruction held for decode
    logic [31:0] m_instr;
    logic [31:0] m_idpc;
    logic        m_out;       // a granted request awaits its response
    logic        m_drop;      // that response is to be thrown away
    logic        m_mis;

    // Memory-side responder state for random traffic.
    logic        mem_pend;
    int          mem_cnt;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .npc           (npc),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .if_id_valid   (if_id_valid),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .fetch_pc      (fetch_pc),
        .fetch_misalign(fetch_misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic exp_req();
        logic ok;
        ok = m_started && !m_valid && !m_out && !m_mis;
`ifdef FETCH_ALIGN_CHECK_EN
        ok = ok && (m_fetch[1:0] == 2'b00);
`endif
        return ok;
    endfunction

    function automatic logic [31:0] exp_addr();
`ifdef FETCH_ALIGN_CHECK_EN
        return m_fetch;
`else
        return m_fetch & 32'hFFFF_FFFC;
`endif
    endfunction

    task automatic model_reset();
        m_started = 1'b0;
        m_fetch   = RESET_PC;
        m_valid   = 1'b0;
        m_instr   = 32'h0;
        m_idpc    = 32'h0;
        m_out     = 1'b0;
        m_drop    = 1'b0;
        m_mis     = 1'b0;
        mem_pend  = 1'b0;
        mem_cnt   = 0;
    endtask

    // Advance the model by one clock edge using the inputs held across it.
    task automatic model_edge();
        logic granted;
        granted = exp_req() && imem_gnt;
        if (redirect) begin
            if (granted) m_out = 1'b1;
            if (m_out) m_drop = 1'b1;
            m_fetch = redirect_pc;
            m_valid = 1'b0;
            m_mis   = 1'b0;
            $display("redirect    pc=0x%08h drop=%0b", redirect_pc, m_drop);
        end else if (granted) begin
            m_out = 1'b1;
        end else if (m_out && imem_rvalid) begin
            m_out = 1'b0;
            if (m_drop) begin
                m_drop = 1'b0;
                $display("discard     data=0x%08h", imem_rdata);
            end else begin
                m_valid = 1'b1;
                m_instr = imem_rdata;
                m_idpc  = m_fetch;
                $display("capture     pc=0x%08h instr=0x%08h", m_fetch, imem_rdata);
            end
        end else if (m_valid && !stall) begin
            m_valid = 1'b0;
            m_fetch = npc;
        end
`ifdef FETCH_ALIGN_CHECK_EN
        else if (m_started && !m_valid && !m_out && !m_mis && (m_fetch[1:0] != 2'b00)) begin
            m_mis = 1'b1;
        end
`endif
        m_started = 1'b1;
    endtask

    task automatic check_outputs();
        check("req", {31'h0, imem_req}, {31'h0, exp_req()});
        if (exp_req()) check("addr", imem_addr, exp_addr());
        check("fetch_pc", fetch_pc, m_fetch);
        check("if_id_valid", {31'h0, if_id_valid}, {31'h0, m_valid});
        check("if_id_instr", if_id_instr, m_instr);
        check("if_id_pc", if_id_pc, m_idpc);
        check("misalign", {31'h0, fetch_misalign}, {31'h0, m_mis});
    endtask

    // One clock: drive inputs (called at the falling edge), update model, check.
    task automatic step(input logic g, input logic rv, input logic [31:0] rd,
                        input logic st, input logic [31:0] np,
                        input logic re, input logic [31:0] rpc);
        imem_gnt    = g;
        imem_rvalid = rv;
        imem_rdata  = rd;
        stall       = st;
        npc         = np;
        redirect    = re;
        redirect_pc = rpc;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_inputs();
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        stall = 1'b0; npc = 32'h0; redirect = 1'b0; redirect_pc = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
        reset_n = 1'b1;
    endtask

    initial begin
        logic        g, rv, st, re;
        logic [31:0] rd, np, rpc;

        idle_inputs();
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        check_outputs();
        check("rst_fetch_pc", fetch_pc, 32'h0000_3000);
        reset_n = 1'b1;

        // First fetch after reset, immediate grant, response next cycle.
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("first_addr", imem_addr, 32'h0000_3000);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h3C01_0001, 1'b1, 32'h3004, 1'b0, 32'h0);
        check("first_instr", if_id_instr, 32'h3C01_0001);
        check("first_pc", if_id_pc, 32'h0000_3000);

        // Decode stalls three cycles, then consumes.
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b1, 32'h3004, 1'b0, 32'h0);
        check("stall_hold", {31'h0, if_id_valid}, 32'h1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h3004, 1'b0, 32'h0);
        check("npc_addr", imem_addr, 32'h0000_3004);

        // Grant withheld four cycles.
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("gnt_wait_addr", imem_addr, 32'h0000_3004);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);

        // Redirect in WAIT; stale response two cycles later is dropped.
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h4180);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 32'h0);
        check("stale_instr", if_id_instr, 32'h3C01_0001);
        check("redir_addr", imem_addr, 32'h0000_4180);

        // Redirect in DECODE under stall wins.
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h0000_0020, 1'b1, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h5000);
        check("redir_dec_addr", imem_addr, 32'h0000_5000);

        // Misaligned next PC.
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h2402_0005, 1'b1, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h3006, 1'b0, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        check("mis_noreq", {31'h0, imem_req}, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("mis_flag", {31'h0, fetch_misalign}, 32'h1);
`else
        check("mask_addr", imem_addr, 32'h0000_3004);
`endif
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h3008);
        check("realign_addr", imem_addr, 32'h0000_3008);

        // Randomized traffic with a responder of 1..3 cycle latency.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            rv = 1'b0;
            rd = $urandom;
            if (mem_pend) begin
                if (mem_cnt == 0) begin
                    rv = 1'b1;
                    mem_pend = 1'b0;
                end else begin
                    mem_cnt--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                rv = 1'b1;
            end
            g = exp_req() ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 1) == 1);
            if (exp_req() && g) begin
                mem_pend = 1'b1;
                mem_cnt  = $urandom_range(0, 2);
            end
            st = ($urandom_range(0, 1) == 1);
            np = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) np = $urandom;
            re  = !rv && ($urandom_range(0, 11) == 0);
            rpc = $urandom & 32'hFFFF_FFFC;
            step(g, rv, rd, st, np, re, rpc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the MIPS core, directly upstream of the next-PC logic. Holds the fetch PC (reset 0x0000_3000), issues one-outstanding word requests to instruction memory, and presents the returned instruction plus its PC in an IF/ID register to decode/NPC. It then loads the next-PC value computed downstream when decode accepts the instruction. It also handles redirects, including discarding an in-flight response.

## Interface
- RESET_PC, 32'h0000_3000, fetch PC after reset
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- npc  in  32  next PC from NPC; sampled only when IF/ID is consumed
- stall  in  1  decode/hazard hold; IF/ID held while 1
- redirect  in  1  force fetch from redirect_pc; highest priority
- redirect_pc  in  32  redirect target
- imem_req  out  1  request valid
- imem_addr  out  32  word address of request
- imem_gnt  in  1  request accepted this cycle (same cycle as imem_req)
- imem_rvalid  in  1  response valid, ≥1 cycle after grant
- imem_rdata  in  32  instruction word
- if_id_valid  out  1  IF/ID holds a live instruction
- if_id_instr  out  32  instruction to decode (op/func/imm16/imm26 source)
- if_id_pc  out  32  PC of if_id_instr; drives NPC pc input
- fetch_pc  out  32  current fetch PC register
- fetch_misalign  out  1  sticky misalignment flag (see Configuration)

## Operation
- States: IDLE, FETCH, WAIT, DECODE, DRAIN, ERR. Reset: state=IDLE, fetch_pc=RESET_PC, if_id_valid=0, if_id_instr=0, if_id_pc=0, fetch_misalign=0, imem_req=0.
- IDLE: go to FETCH unconditionally.
- FETCH: imem_req=1, imem_addr=fetch_pc. On imem_gnt, go to WAIT. Otherwise stay, holding the address stable.
- WAIT: imem_req=0. On imem_rvalid: if_id_instr<=imem_rdata, if_id_pc<=fetch_pc, if_id_valid<=1, then go to DECODE.
- DECODE: if stall=0, fetch_pc<=npc, if_id_valid<=0, go to FETCH. If stall=1, hold all state.
- Redirect has priority over every other transition:
  - In all states: fetch_pc<=redirect_pc and if_id_valid<=0.
  - From WAIT, and from FETCH when imem_gnt=1 in the same cycle: go to DRAIN.
  - From all other states: go to FETCH.
- DRAIN: the next imem_rvalid is discarded (IF/ID untouched), then go to FETCH. A further redirect in DRAIN updates fetch_pc and stays in DRAIN.
- imem_rvalid outside WAIT/DRAIN is ignored.
- Arithmetic: none inside the block. All addresses are taken verbatim from npc/redirect_pc, 32-bit.

## Timing
- Reset released at edge 0: IDLE at edge 0, imem_req=1 in the cycle after edge 1, addr=RESET_PC.
- Minimum instruction period with gnt in the request cycle and rvalid one cycle later: 3 cycles (FETCH, WAIT, DECODE).
- if_id_* change only on rvalid capture or redirect. They are stable throughout DECODE, so npc is combinationally valid there.
- imem_req/imem_addr are functions of registered state only; no combinational path from imem_gnt.
- Reset asserted mid-transaction returns to the reset values immediately. The memory side must drop its response; the block ignores any rvalid until it is back in WAIT.

## Configuration
- FETCH_ALIGN_CHECK_EN defined:
  - In FETCH, if fetch_pc[1:0]!=0, no request is issued; set fetch_misalign=1 and go to ERR.
  - ERR holds with imem_req=0 until redirect.
  - Redirect clears fetch_misalign, then the normal redirect rules apply.
- FETCH_ALIGN_CHECK_EN undefined: imem_addr={fetch_pc[31:2],2'b00}, fetch_misalign tied 0, ERR unreachable.

## Test plan
- Reset, gnt=1 immediately, rvalid next cycle with rdata=0x3C010001 -> imem_addr=0x3000; if_id_instr=0x3C010001, if_id_pc=0x3000, valid=1.
- DECODE with npc=0x3004, stall=1 for 3 cycles then 0 -> IF/ID held for 3 cycles; next request addr=0x3004, valid drops on release.
- gnt withheld 4 cycles -> imem_req stays 1 and imem_addr stays 0x3004 until the grant.
- Redirect to 0x4180 while in WAIT; the stale rvalid (rdata=0xDEADBEEF) arrives 2 cycles later -> IF/ID not loaded, valid=0; next request addr=0x4180.
- Redirect in DECODE with stall=1 -> redirect wins; valid=0, next request to redirect_pc.
- With FETCH_ALIGN_CHECK_EN, npc=0x3006 -> no request, fetch_misalign=1; redirect 0x3008 clears it and fetches 0x3008. Without the macro -> imem_addr=0x3004.
